// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers and a direct mthi/mtlo path.
// Latency: busy for MULT_CYC+1 (mult) or DIV_CYC+1 (div) cycles; HI/LO readable the cycle after.
// Backpressure: a start outside IDLE is dropped, never queued; busy gates the register-file write.
module mdu #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  md_op,
   input  logic [1:0]  mt_we,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [2:0]  busy
);

   // The counter must hold the larger of the two run lengths.
   localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   a_q;
   logic [31:0]   b_q;
   logic [1:0]    op_q;
   logic          run_flag;
   logic          commit_flag;

   logic [31:0]   res_hi;
   logic [31:0]   res_lo;
   logic [63:0]   prod_s;
   logic [63:0]   prod_u;

   // Both products are formed at full 64-bit width so the upper word is exact.
   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Result selection from the latched operands; divide-by-zero and the one
   // signed overflow case are resolved explicitly rather than left to '/'.
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (op_q)
         OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV: begin
            if (b_q == 32'd0) begin
               res_hi = a_q;
               res_lo = 32'hFFFF_FFFF;
            end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
               res_hi = 32'd0;
               res_lo = 32'h8000_0000;
            end else begin
               res_lo = $signed(a_q) / $signed(b_q);
               res_hi = $signed(a_q) % $signed(b_q);
            end
         end
         default: begin
            if (b_q == 32'd0) begin
               res_hi = a_q;
               res_lo = 32'hFFFF_FFFF;
            end else begin
               res_lo = a_q / b_q;
               res_hi = a_q % b_q;
            end
         end
      endcase
   end

   // Control FSM plus HI/LO ownership. RUN lasts CYC-1 cycles: the counter is
   // loaded with CYC-1 and the FSM leaves RUN on the edge that takes it to 0,
   // so accept + RUN + COMMIT spans CYC+1 busy cycles. CYC values below 2
   // still work but stretch to a minimum of three busy cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         op_q        <= 2'd0;
         HI          <= 32'd0;
         LO          <= 32'd0;
         run_flag    <= 1'b0;
         commit_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q      <= A;
                  b_q      <= B;
                  op_q     <= md_op;
                  cnt      <= md_op[1] ? CW'(DIV_CYC - 1) : CW'(MULT_CYC - 1);
                  state    <= RUN;
                  run_flag <= 1'b1;
               end else begin
                  if (mt_we[1]) HI <= A;
                  if (mt_we[0]) LO <= A;
               end
            end
            RUN: begin
               if (cnt <= CW'(1)) begin
                  cnt         <= '0;
                  state       <= COMMIT;
                  run_flag    <= 1'b0;
                  commit_flag <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            COMMIT: begin
               HI          <= res_hi;
               LO          <= res_lo;
               state       <= IDLE;
               commit_flag <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               run_flag    <= 1'b0;
               commit_flag <= 1'b0;
            end
         endcase
      end
   end

   // The accept bit is combinational so the register file stalls in the start cycle itself.
   assign busy = {commit_flag, (start && state == IDLE), run_flag};

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios followed by random operations
// checked against a 64-bit arithmetic reference model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mdu;

   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  md_op;
   logic [1:0]  mt_we;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [2:0]  busy;

   int compared   = 0;
   int mismatched = 0;

   mdu #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .mt_we(mt_we),
      .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sq, sr, sp;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         2'd0: begin sp = sa * sb; return sp; end
         2'd1: return ua * ub;
         2'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {32'((ua % ub)), 32'((ua / ub))};
         end
      endcase
   endfunction

   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   // Issues one operation and follows it to completion. disturb=1 pulses a
   // competing start and mthi/mtlo mid-run; mt_with_start raises mt_we alongside start.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb, input bit mt_with_start);
      int          cycles;
      logic [2:0]  last_busy;
      logic [63:0] exp;
      int          lat;
      exp = ref_result(op, a, b);
      lat = (op >= 2'd2) ? DIV_CYC + 1 : MULT_CYC + 1;
      @(negedge clk);
      start = 1'b1; md_op = op; A = a; B = b;
      mt_we = mt_with_start ? 2'b11 : 2'b00;
      #1;
      chk({tag, "_accept_busy"}, {61'd0, busy}, 64'd2);
      cycles = 0;
      last_busy = 3'd0;
      while (busy != 3'd0 && cycles < 40) begin
         cycles++;
         last_busy = busy;
         @(negedge clk);
         start = 1'b0; mt_we = 2'b00;
         A = $urandom; B = $urandom;
         if (disturb && cycles == 2) begin
            start = 1'b1; md_op = 2'd0; mt_we = 2'b11;
         end
         #1;
         if (cycles == 1) begin
            chk({tag, "_run_busy"}, {61'd0, busy}, 64'd1);
            chk({tag, "_hold_hilo"}, {HI, LO}, {exp_hi, exp_lo});
         end
      end
      start = 1'b0; mt_we = 2'b00;
      chk({tag, "_busy_cycles"}, 64'(cycles), 64'(lat));
      chk({tag, "_commit_busy"}, {61'd0, last_busy}, 64'd4);
      chk({tag, "_hilo"}, {HI, LO}, exp);
      exp_hi = exp[63:32];
      exp_lo = exp[31:0];
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; md_op = 2'd0; mt_we = 2'b00; A = 32'd0; B = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_busy", {61'd0, busy}, 64'd0);
      chk("reset_hilo", {HI, LO}, 64'd0);

      do_op("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      chk("mult_neg_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
      do_op("multu", 2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      chk("multu_const", {HI, LO}, {32'd1, 32'hFFFF_FFFE});
      do_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      chk("div_neg_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      do_op("divu_zero", 2'd3, 32'd100, 32'd0, 1'b0, 1'b0);
      chk("divu_zero_const", {HI, LO}, {32'd100, 32'hFFFF_FFFF});
      do_op("div_zero", 2'd2, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
      do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("div_ovf_const", {HI, LO}, {32'd0, 32'h8000_0000});
      do_op("div_disturb", 2'd2, 32'd1000, 32'd7, 1'b1, 1'b0);
      chk("div_disturb_const", {HI, LO}, {32'd6, 32'd142});
      do_op("start_wins", 2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);

      // Direct mtlo then mthi in IDLE.
      @(negedge clk);
      mt_we = 2'b01; A = 32'hCAFE_0001;
      @(negedge clk);
      mt_we = 2'b00;
      #1;
      chk("mtlo", {HI, LO}, {exp_hi, 32'hCAFE_0001});
      exp_lo = 32'hCAFE_0001;

      for (int i = 0; i < 24; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if (i % 6 == 5) b = 32'd0;
         if (i % 8 == 3) b = 32'($urandom_range(1, 9));
         if (i % 5 == 2) b = -b;
         do_op("rand", op, a, b, (i % 4 == 1), (i % 7 == 2));
      end

      // Reset two cycles into RUN discards the multiply.
      do_op("pre_reset", 2'd1, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1; md_op = 2'd0; A = 32'd77; B = 32'd99;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_run_busy", {61'd0, busy}, 64'd0);
      chk("rst_run_hilo", {HI, LO}, 64'd0);
      repeat (12) @(negedge clk);
      #1;
      chk("rst_no_commit_busy", {61'd0, busy}, 64'd0);
      chk("rst_no_commit_hilo", {HI, LO}, 64'd0);
      @(negedge clk);
      mt_we = 2'b10; A = 32'h1234_5678;
      @(negedge clk);
      mt_we = 2'b00;
      #1;
      chk("mthi_after_reset", {HI, LO}, {32'h1234_5678, 32'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
